spi_tx_queue: RTL and testbench

Upstream feeder for the SPI slave transmitter: buffers 64-bit words written by user logic in a DEPTH-entry FIFO. Presents the head word on `txd_data`/`txd_en` and holds it stable for the whole SPI read. Retires the word on the transmitter's `txd_flag` (CS-rise) pulse. Counts dropped writes and underruns (reads with no word loaded) for the status registers.

---
 rtl/spi_tx_queue.sv | 106 ++++++++++
 tb/tb_spi_tx_queue.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_queue.sv
// Transmit-side word queue for the SPI slave: buffers 64-bit words, presents the
// head word to the transmitter and retires it on each CS-rise pulse.
module spi_tx_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [63:0]      wr_data,
    input  logic             flush,
    output logic             full,
    output logic [LVL_W-1:0] level,
    output logic             txd_en,
    output logic [63:0]      txd_data,
    input  logic             txd_flag,
    output logic [15:0]      ovf_cnt,
    output logic [15:0]      udr_cnt
);
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    logic [63:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [1:0]       state_q, state_d;
    logic [63:0]      txd_data_q, txd_data_d;
    logic [15:0]      ovf_q, ovf_d;
    logic [15:0]      udr_q, udr_d;
    logic             wr_acc;
    logic             pop;

    assign full     = (count_q == LVL_W'(DEPTH));
    assign level    = count_q;
    assign txd_en   = (state_q == ST_SHOW);
    assign txd_data = txd_data_q;
    assign ovf_cnt  = ovf_q;
    assign udr_cnt  = udr_q;

    always_comb begin
        wr_acc     = wr_en && !full && !flush;
        pop        = txd_flag && (state_q == ST_SHOW) && !flush;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        state_d    = state_q;
        txd_data_d = txd_data_q;
        ovf_d      = ovf_q;
        udr_d      = udr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = ST_EMPTY;
        end else begin
            if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)    rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + LVL_W'(wr_acc) - LVL_W'(pop);
            // A write while full is dropped even if a pop frees a slot this cycle.
            if (wr_en && full && ovf_q != '1)
                ovf_d = ovf_q + 16'd1;
            if (txd_flag && state_q != ST_SHOW && udr_q != '1)
                udr_d = udr_q + 16'd1;
            case (state_q)
                ST_EMPTY: if (count_q != '0) state_d = ST_LOAD;
                ST_LOAD: begin
                    txd_data_d = mem_q[rd_ptr_q];
                    state_d    = ST_SHOW;
                end
                ST_SHOW: if (pop) state_d = (count_d != '0) ? ST_LOAD : ST_EMPTY;
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            state_q    <= ST_EMPTY;
            txd_data_q <= '0;
            ovf_q      <= '0;
            udr_q      <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            state_q    <= state_d;
            txd_data_q <= txd_data_d;
            ovf_q      <= ovf_d;
            udr_q      <= udr_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc)
            mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: tb/tb_spi_tx_queue.sv
// Bench for spi_tx_queue: directed scenarios plus a randomized run against a
// queue-based reference model of the word stream and presentation timing.
module tb_spi_tx_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned LVL_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [63:0]      wr_data = '0;
    logic             flush = 1'b0;
    logic             txd_flag = 1'b0;
    logic             full;
    logic [LVL_W-1:0] level;
    logic             txd_en;
    logic [63:0]      txd_data;
    logic [15:0]      ovf_cnt;
    logic [15:0]      udr_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored words, edges until the head word is presented
    // (0 = presented, -1 = nothing pending), last presented value, counters.
    logic [63:0] mq[$];
    int          m_show_in = -1;
    logic [63:0] m_data = '0;
    logic [15:0] m_ovf = '0;
    logic [15:0] m_udr = '0;

    spi_tx_queue #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
        .full(full), .level(level), .txd_en(txd_en), .txd_data(txd_data),
        .txd_flag(txd_flag), .ovf_cnt(ovf_cnt), .udr_cnt(udr_cnt)
    );

    always #5 clk = ~clk;

    task automatic cycle(input bit w, input logic [63:0] d, input bit fl, input bit fg);
        bit showing, was_full, popped;
        wr_en = w; wr_data = d; flush = fl; txd_flag = fg;
        @(posedge clk);
        if (fl) begin
            mq.delete();
            m_show_in = -1;
        end else begin
            showing  = (m_show_in == 0);
            was_full = (mq.size() == DEPTH);
            popped   = showing && fg;
            if (fg && !showing && m_udr != 16'hFFFF) m_udr++;
            if (w && was_full && m_ovf != 16'hFFFF) m_ovf++;
            if (popped) void'(mq.pop_front());
            if (w && !was_full) mq.push_back(d);
            if (popped) m_show_in = (mq.size() != 0) ? 1 : -1;
            else if (m_show_in > 0) begin
                m_show_in--;
                if (m_show_in == 0) m_data = mq[0];
            end else if (m_show_in < 0 && mq.size() != 0) m_show_in = 2;
        end
        #1;
        wr_en = 1'b0; flush = 1'b0; txd_flag = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mq.delete(); m_show_in = -1; m_data = '0; m_ovf = '0; m_udr = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (txd_en !== 1'b0) begin n_fail++; $display("FAIL reset_txd_en got=%b exp=0", txd_en); end
        n_checks++; if (txd_data !== 64'h0) begin n_fail++; $display("FAIL reset_txd_data got=%h exp=0", txd_data); end
        n_checks++; if (level !== 3'd0 || full !== 1'b0) begin n_fail++; $display("FAIL reset_level got=%0d/%b exp=0/0", level, full); end
        n_checks++; if (ovf_cnt !== 16'd0 || udr_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnts got=%0d/%0d exp=0/0", ovf_cnt, udr_cnt); end
    endtask

    task automatic test_single_word();
        do_reset();
        cycle(1'b1, 64'hA5A5_0000_1234_FFFF, 1'b0, 1'b0);
        n_checks++; if (level !== 3'd1 || txd_en !== 1'b0) begin n_fail++; $display("FAIL single_after_N got lvl=%0d en=%b exp 1/0", level, txd_en); end
        idle(1);
        n_checks++; if (txd_en !== 1'b0) begin n_fail++; $display("FAIL single_load_en got=%b exp=0", txd_en); end
        idle(1);
        n_checks++; if (txd_en !== 1'b1 || txd_data !== 64'hA5A5_0000_1234_FFFF) begin n_fail++; $display("FAIL single_show got en=%b data=%h exp 1/a5a500001234ffff", txd_en, txd_data); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++; if (txd_en !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL single_pop got en=%b lvl=%0d exp 0/0", txd_en, level); end
        idle(2);
        n_checks++; if (txd_en !== 1'b0 || udr_cnt !== 16'd0) begin n_fail++; $display("FAIL single_empty got en=%b udr=%0d exp 0/0", txd_en, udr_cnt); end
    endtask

    task automatic test_fill_overflow();
        logic [63:0] w [6];
        do_reset();
        for (int i = 0; i < 6; i++) begin
            w[i] = {$urandom, $urandom};
            cycle(1'b1, w[i], 1'b0, 1'b0);
        end
        n_checks++; if (full !== 1'b1 || level !== 3'd4 || ovf_cnt !== 16'd2) begin n_fail++; $display("FAIL fill_state got full=%b lvl=%0d ovf=%0d exp 1/4/2", full, level, ovf_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (txd_en !== 1'b1 || txd_data !== w[i]) begin n_fail++; $display("FAIL fill_word%0d got en=%b data=%h exp 1/%h", i, txd_en, txd_data, w[i]); end
            cycle(1'b0, '0, 1'b0, 1'b1);
            n_checks++; if (txd_en !== 1'b0) begin n_fail++; $display("FAIL fill_gap%0d got en=%b exp=0", i, txd_en); end
            idle(1);
        end
        n_checks++; if (txd_en !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL fill_drained got en=%b lvl=%0d exp 0/0", txd_en, level); end
    endtask

    task automatic test_underrun();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1);
        n_checks++; if (udr_cnt !== 16'd3 || txd_en !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL underrun got udr=%0d en=%b lvl=%0d exp 3/0/0", udr_cnt, txd_en, level); end
        cycle(1'b1, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
        idle(2);
        n_checks++; if (txd_en !== 1'b1 || txd_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL underrun_next got en=%b data=%h exp 1/0123456789abcdef", txd_en, txd_data); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        cycle(1'b1, 64'h1111, 1'b0, 1'b0);
        cycle(1'b1, 64'h2222, 1'b0, 1'b0);
        idle(1);
        n_checks++; if (level !== 3'd2 || txd_en !== 1'b1 || txd_data !== 64'h1111) begin n_fail++; $display("FAIL b2b_pre got lvl=%0d en=%b data=%h exp 2/1/1111", level, txd_en, txd_data); end
        cycle(1'b1, 64'h3333, 1'b0, 1'b1);
        n_checks++; if (level !== 3'd2 || txd_en !== 1'b0) begin n_fail++; $display("FAIL b2b_pop got lvl=%0d en=%b exp 2/0", level, txd_en); end
        idle(1);
        n_checks++; if (txd_en !== 1'b1 || txd_data !== 64'h2222) begin n_fail++; $display("FAIL b2b_word2 got en=%b data=%h exp 1/2222", txd_en, txd_data); end
        cycle(1'b0, '0, 1'b0, 1'b1);
        idle(1);
        n_checks++; if (txd_en !== 1'b1 || txd_data !== 64'h3333) begin n_fail++; $display("FAIL b2b_word3 got en=%b data=%h exp 1/3333", txd_en, txd_data); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b1, 64'(i + 16), 1'b0, 1'b0);
        n_checks++; if (level !== 3'd4 || txd_en !== 1'b1) begin n_fail++; $display("FAIL fullpop_pre got lvl=%0d en=%b exp 4/1", level, txd_en); end
        cycle(1'b1, 64'hDEAD, 1'b0, 1'b1);
        n_checks++; if (ovf_cnt !== 16'd1 || level !== 3'd3 || full !== 1'b0) begin n_fail++; $display("FAIL fullpop got ovf=%0d lvl=%0d full=%b exp 1/3/0", ovf_cnt, level, full); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0);
        n_checks++; if (txd_en !== 1'b1 || level !== 3'd3) begin n_fail++; $display("FAIL flush_pre got en=%b lvl=%0d exp 1/3", txd_en, level); end
        cycle(1'b1, 64'hBAD, 1'b1, 1'b1);
        n_checks++; if (txd_en !== 1'b0 || level !== 3'd0 || txd_data !== 64'hC0) begin n_fail++; $display("FAIL flush got en=%b lvl=%0d data=%h exp 0/0/c0", txd_en, level, txd_data); end
        n_checks++; if (udr_cnt !== 16'd1 || ovf_cnt !== 16'd0) begin n_fail++; $display("FAIL flush_cnts got udr=%0d ovf=%0d exp 1/0", udr_cnt, ovf_cnt); end
        idle(3);
        n_checks++; if (txd_en !== 1'b0 || level !== 3'd0) begin n_fail++; $display("FAIL flush_stays got en=%b lvl=%0d exp 0/0", txd_en, level); end
        for (int i = 0; i < 3; i++) cycle(1'b1, 64'hE0 + 64'(i), 1'b0, 1'b0);
        do_reset();
        n_checks++; if (txd_en !== 1'b0 || level !== 3'd0 || txd_data !== 64'h0 || udr_cnt !== 16'd0 || ovf_cnt !== 16'd0 || full !== 1'b0)
            begin n_fail++; $display("FAIL midop_reset got en=%b lvl=%0d data=%h udr=%0d ovf=%0d exp all zero", txd_en, level, txd_data, udr_cnt, ovf_cnt); end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cycle($urandom_range(0, 9) < 6, {$urandom, $urandom},
                  $urandom_range(0, 59) == 0, $urandom_range(0, 9) < 3);
            n_checks++;
            if (txd_en !== (m_show_in == 0) || txd_data !== m_data || level !== LVL_W'(mq.size())
                || full !== (mq.size() == DEPTH) || ovf_cnt !== m_ovf || udr_cnt !== m_udr) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random cyc=%0d got en=%b data=%h lvl=%0d full=%b ovf=%0d udr=%0d exp en=%b data=%h lvl=%0d ovf=%0d udr=%0d",
                             i, txd_en, txd_data, level, full, ovf_cnt, udr_cnt,
                             m_show_in == 0, m_data, mq.size(), m_ovf, m_udr);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_fill_overflow();
        test_underrun();
        test_back_to_back();
        test_full_pop();
        test_flush_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
